instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle execute datapath. Owns the program counter, drives the synchronous instruction ROM (one-cycle read latency), buffers returned words in a small FIFO and presents them to execute with a valid/ready handshake. Accepts PC redirects from execute for branches, JAL and JALR, and stops fetching on an unrecognised opcode.

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives a one-cycle-latency ROM and
// buffers returned words in a small FIFO handed to execute via valid/ready.
module instr_fetch #(
    parameter int unsigned         PC_WIDTH = 11,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned         DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                rom_en,
    output logic [7:0]          rom_addr,
    input  logic [31:0]         rom_q,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic [PC_WIDTH-1:0] instr_pc_plus4,
    input  logic                instr_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                inflight_q, inflight_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                halt_pending_q, halt_pending_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [31:0]         mem_instr_q [DEPTH];
    logic [31:0]         mem_instr_d [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc_q [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc_d [DEPTH];

    logic                pop;
    logic                push;
    logic                bad_op;
    logic                issue;
    logic [CW-1:0]       occupancy;

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
            7'b1100011, 7'b1101111, 7'b1100111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Next-state: issue, capture, FIFO push/pop and redirect flush.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        inflight_d     = inflight_q;
        inflight_pc_d  = inflight_pc_q;
        halt_pending_d = halt_pending_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        mem_instr_d    = mem_instr_q;
        mem_pc_d       = mem_pc_q;

        pop       = instr_valid & instr_ready;
        occupancy = count_q - CW'(pop) + CW'(inflight_q);
        issue     = rst_n & ~redirect_valid & ~halt_pending_q & (occupancy < CW'(DEPTH));
        push      = inflight_q & ~redirect_valid & opcode_legal(rom_q[6:0]);
        bad_op    = inflight_q & ~redirect_valid & ~opcode_legal(rom_q[6:0]);

        if (redirect_valid) begin
            fetch_pc_d     = redirect_pc & ~PC_WIDTH'(3);
            inflight_d     = 1'b0;
            halt_pending_d = 1'b0;
            rd_ptr_d       = '0;
            wr_ptr_d       = '0;
            count_d        = '0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + PC_WIDTH'(4);
            end else begin
                inflight_d = 1'b0;
            end
            // A fetch issued alongside the bad word is speculative past it; drop it.
            if (bad_op) begin
                halt_pending_d = 1'b1;
                inflight_d     = 1'b0;
            end
            if (push) begin
                mem_instr_d[wr_ptr_q] = rom_q;
                mem_pc_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d              = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q     <= RESET_PC;
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
            halt_pending_q <= 1'b0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            inflight_q     <= inflight_d;
            inflight_pc_q  <= inflight_pc_d;
            halt_pending_q <= halt_pending_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
        end
    end

    // Payload storage needs no reset: head outputs are gated by instr_valid.
    always_ff @(posedge clk) begin
        mem_instr_q <= mem_instr_d;
        mem_pc_q    <= mem_pc_d;
    end

    assign instr_valid    = (count_q != '0);
    assign instr          = instr_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign instr_pc       = instr_valid ? mem_pc_q[rd_ptr_q] : '0;
    assign instr_pc_plus4 = instr_valid ? mem_pc_q[rd_ptr_q] + PC_WIDTH'(4) : '0;
    assign rom_en         = issue;
    assign rom_addr       = fetch_pc_q[9:2];
    assign halted         = halt_pending_q & ~instr_valid & ~inflight_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed timing checks plus a random run scored
// against a program-order model of the expected instruction stream.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [31:0] rom_q;
    logic        instr_valid;
    logic [31:0] instr;
    logic [10:0] instr_pc;
    logic [10:0] instr_pc_plus4;
    logic        instr_ready;
    logic        redirect_valid;
    logic [10:0] redirect_pc;
    logic        halted;

    logic [31:0] rom [256];
    logic [10:0] exp_pc;
    int          errors;
    int          checks;
    int          n_pops;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_q          (rom_q),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rom_en) rom_q <= rom[rom_addr];
    end

    function automatic logic legal_word(input logic [31:0] w);
        return w[6:0] inside {7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
                              7'b1100011, 7'b1101111, 7'b1100111};
    endfunction

    function automatic logic [31:0] legal_rand();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 6))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0100011;
            3: w[6:0] = 7'b0000011;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b1101111;
            default: w[6:0] = 7'b1100111;
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One cycle: drive at negedge, then score outputs before the next posedge.
    task automatic step(input logic rst, input logic rdy, input logic rv, input logic [10:0] rpc);
        logic [10:0] p4;
        @(negedge clk);
        rst_n          = rst;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (halted === 1'b1) begin
            chk("halt_next_word_illegal", 32'(legal_word(rom[exp_pc[9:2]])), 32'd0);
            chk("halt_no_valid", 32'(instr_valid), 32'd0);
        end
        if (instr_valid === 1'b1 && rdy) begin
            p4 = exp_pc + 11'd4;
            chk("sb_pc", 32'(instr_pc), 32'(exp_pc));
            chk("sb_instr", instr, rom[exp_pc[9:2]]);
            chk("sb_pc_plus4", 32'(instr_pc_plus4), 32'(p4));
            exp_pc = p4;
            n_pops++;
        end
        if (!rst) exp_pc = 11'h000;
        else if (rv) exp_pc = {rpc[10:2], 2'b00};
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, rdy, 1'b0, 11'($urandom()));
    endtask

    task automatic chk_reset_outputs(input string tag, input logic en_exp);
        chk({tag, "_rom_en"}, 32'(rom_en), 32'(en_exp));
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_pc"}, 32'(instr_pc), 32'd0);
        chk({tag, "_pc_plus4"}, 32'(instr_pc_plus4), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        int rand_pops;
        errors = 0;
        checks = 0;
        n_pops = 0;
        exp_pc = 11'h000;
        rst_n = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        for (int i = 0; i < 256; i++) rom[i] = legal_rand();

        // Reset values
        step(1'b0, 1'b0, 1'b0, 11'h0);
        step(1'b0, 1'b1, 1'b0, 11'h0);
        chk_reset_outputs("reset", 1'b0);

        // Streaming with ready high: one issue per cycle, valid from cycle 2
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 1'b0, 11'($urandom()));
            chk("t1_rom_addr", 32'(rom_addr), 32'(c));
            chk("t1_rom_en", 32'(rom_en), 32'd1);
            chk("t1_valid", 32'(instr_valid), 32'(c >= 2));
        end

        // Back-pressure: FIFO fills, issue stops, order preserved on release
        step(1'b0, 1'b0, 1'b0, 11'h0);
        run(2, 1'b1);
        for (int c = 2; c < 7; c++) begin
            step(1'b1, 1'b0, 1'b0, 11'($urandom()));
            chk("t2_valid_held", 32'(instr_valid), 32'd1);
            if (c >= 3) chk("t2_rom_en_stall", 32'(rom_en), 32'd0);
        end
        for (int c = 7; c < 10; c++) begin
            step(1'b1, 1'b1, 1'b0, 11'($urandom()));
            chk("t2_release_pc", 32'(instr_pc), 32'((c - 7) * 4));
        end

        // Redirect while full
        step(1'b0, 1'b0, 1'b0, 11'h0);
        run(4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 11'h02A);
        chk("t3_full_at_R", 32'(instr_valid), 32'd1);
        chk("t3_rom_en_R", 32'(rom_en), 32'd0);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t3_rom_addr_R1", 32'(rom_addr), 32'h0A);
        chk("t3_rom_en_R1", 32'(rom_en), 32'd1);
        chk("t3_valid_R1", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t3_valid_R2", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t3_valid_R3", 32'(instr_valid), 32'd1);
        chk("t3_pc_R3", 32'(instr_pc), 32'h028);

        // Illegal word at 0x00C: halt after 0x008 pops, then redirect resumes
        step(1'b0, 1'b1, 1'b0, 11'h0);
        rom[3] = 32'h0000_0000;
        for (int c = 0; c < 9; c++) begin
            step(1'b1, 1'b1, 1'b0, 11'($urandom()));
            chk("t4_halted", 32'(halted), 32'(c >= 5));
            if (c >= 5) chk("t4_rom_en_halted", 32'(rom_en), 32'd0);
        end
        step(1'b1, 1'b1, 1'b1, 11'h000);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t4_halt_cleared", 32'(halted), 32'd0);
        chk("t4_resume_en", 32'(rom_en), 32'd1);
        chk("t4_resume_addr", 32'(rom_addr), 32'd0);
        run(1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t4_resume_pc", 32'(instr_pc), 32'd0);
        run(6, 1'b1);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 1'b0, 11'h0);
        rom[3] = legal_rand();
        run(4, 1'b1);
        step(1'b1, 1'b1, 1'b1, 11'h7F8);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t5_rom_addr", 32'(rom_addr), 32'hFE);
        run(1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t5_pc_7f8", 32'(instr_pc), 32'h7F8);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t5_pc_7fc", 32'(instr_pc), 32'h7FC);
        chk("t5_plus4_wrap", 32'(instr_pc_plus4), 32'h000);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t5_pc_wrapped", 32'(instr_pc), 32'h000);

        // Reset while a fetch is in flight
        step(1'b0, 1'b1, 1'b0, 11'h0);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk_reset_outputs("t6_after_rst", 1'b1);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t6_valid_c1", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 11'h0);
        chk("t6_pc_c2", 32'(instr_pc), 32'd0);
        chk("t6_instr_c2", instr, rom[0]);

        // Random: sparse illegal words, random ready and redirects
        step(1'b0, 1'b0, 1'b0, 11'h0);
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 32'($urandom()) & 32'hFFFF_FF80 : legal_rand();
        rand_pops = n_pops;
        for (int i = 0; i < 3000; i++) begin
            logic rv;
            rv = (halted === 1'b1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            step(1'b1, $urandom_range(0, 3) != 0, rv, 11'($urandom()));
        end
        chk("rand_progress", 32'((n_pops - rand_pops) > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
